// File: rtl/memtest_pkg.sv
// Shared constants and types for the memtest_ram dual-port RAM.
// The optional clear sequencer is enabled with MEMTEST_RAM_INIT_EN.
package memtest_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    // When both ports write one address in the same cycle, port A's data is kept.
    localparam bit PORT_A_WINS = 1'b1;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/memtest_ram_init.sv
// Clear sequencer: walks every address once after reset, writing FILL, then
// moves to RUN and raises ready. Instantiated only under MEMTEST_RAM_INIT_EN.
module memtest_ram_init
    import memtest_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output state_t            state,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              done,
    output logic              ready
);

    state_t            state_q;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_n;
    logic              last;

    assign last = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            addr_q  <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            ready   <= (state_n == RUN);
        end
    end

    // The counter parks on DEPTH-1; it never wraps back to 0.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        init_we = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                if (last) begin
                    state_n = RUN;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            RUN: begin
                state_n = RUN;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

    assign state     = state_q;
    assign init_addr = addr_q;
    assign done      = (state_q == RUN);

endmodule

// File: rtl/memtest_ram.sv
// Dual-port 1024x16 RAM with registered reads, write-through and port-A-wins
// collision handling. MEMTEST_RAM_INIT_EN adds the power-up clear sequencer.
module memtest_ram
    import memtest_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              ready,
    output state_t            state
);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic              run;
    logic              collide;
    logic              wr_a_en;
    logic              wr_b_en;
    logic [DATA_W-1:0] win_data;

`ifdef MEMTEST_RAM_INIT_EN
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              init_done;

    memtest_ram_init u_init (
        .clk       (clk),
        .rst       (rst),
        .state     (state_q),
        .init_we   (init_we),
        .init_addr (init_addr),
        .done      (init_done),
        .ready     (ready)
    );

    assign run = init_done;
`else
    // Without the clear sequencer INIT lasts exactly one edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            ready   <= 1'b0;
        end else begin
            state_q <= RUN;
            ready   <= 1'b1;
        end
    end

    assign run = (state_q == RUN);
`endif

    assign state    = state_q;
    assign collide  = we_a && we_b && (addr_a == addr_b);
    assign win_data = PORT_A_WINS ? data_a : data_b;
    assign wr_a_en  = run && we_a && !(collide && !PORT_A_WINS);
    assign wr_b_en  = run && we_b && !(collide && PORT_A_WINS);

    // The array has no reset; INIT (when present) overwrites every word.
    always_ff @(posedge clk) begin
`ifdef MEMTEST_RAM_INIT_EN
        if (init_we) begin
            mem[init_addr] <= FILL;
        end else begin
            if (wr_a_en) mem[addr_a] <= data_a;
            if (wr_b_en) mem[addr_b] <= data_b;
        end
`else
        if (wr_a_en) mem[addr_a] <= data_a;
        if (wr_b_en) mem[addr_b] <= data_b;
`endif
    end

    // Cross-port reads see the pre-edge word because mem is sampled before update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_a <= '0;
            q_b <= '0;
        end else if (run) begin
            if (we_a) begin
                q_a <= collide ? win_data : data_a;
            end else begin
                q_a <= mem[addr_a];
            end
            if (we_b) begin
                q_b <= collide ? win_data : data_b;
            end else begin
                q_b <= mem[addr_b];
            end
        end
    end

endmodule

// File: tb/tb_memtest_ram.sv
// Directed self-checking bench for memtest_ram; clear-dependent checks are
// compiled only when MEMTEST_RAM_INIT_EN is defined.
module tb_memtest_ram;
    import memtest_pkg::*;

`ifdef MEMTEST_RAM_INIT_EN
    localparam int INIT_CYCLES = DEPTH;
`else
    localparam int INIT_CYCLES = 1;
`endif
    localparam int WAIT_LIMIT = 3000;

    logic              clk;
    logic              rst;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] q_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] q_b;
    logic              ready;
    state_t            state;

    int n_cmp;
    int n_err;

    memtest_ram #(.FILL(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .we_a   (we_a),
        .addr_a (addr_a),
        .data_a (data_a),
        .q_a    (q_a),
        .we_b   (we_b),
        .addr_b (addr_b),
        .data_b (data_b),
        .q_b    (q_b),
        .ready  (ready),
        .state  (state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wa, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                         input logic wb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        we_a   = wa;
        addr_a = aa;
        data_a = da;
        we_b   = wb;
        addr_b = ab;
        data_b = db;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (q_a !== 16'h0000) begin n_err++; $display("FAIL reset_q_a: got %h want 0000", q_a); end
        n_cmp++; if (q_b !== 16'h0000) begin n_err++; $display("FAIL reset_q_b: got %h want 0000", q_b); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (state !== INIT) begin n_err++; $display("FAIL reset_state: got %0d want INIT", state); end
        repeat (3) cycle();
    endtask

    task automatic test_power_up();
        int  edges;
        logic q_dirty;
        edges   = 0;
        q_dirty = 1'b0;
        // traffic offered while not ready must be dropped
        drive(1'b1, 10'h3fe, 16'hFFFF, 1'b1, 10'h3fe, 16'hFFFF);
        rst = 1'b1;
        while (ready !== 1'b1 && edges < WAIT_LIMIT) begin
            cycle();
            edges++;
            if (ready !== 1'b1 && (q_a !== 16'h0000 || q_b !== 16'h0000)) q_dirty = 1'b1;
        end
        idle();
        n_cmp++; if (edges !== INIT_CYCLES) begin n_err++; $display("FAIL clear_duration: ready after %0d edges want %0d", edges, INIT_CYCLES); end
        n_cmp++; if (q_dirty !== 1'b0) begin n_err++; $display("FAIL init_q_hold: q moved during INIT got %b want 0", q_dirty); end
        n_cmp++; if (state !== RUN) begin n_err++; $display("FAIL run_state: got %0d want RUN", state); end
`ifdef MEMTEST_RAM_INIT_EN
        drive(1'b0, 10'h3fe, 16'h0, 1'b0, 10'h3ff, 16'h0);
        cycle();
        n_cmp++; if (q_b !== 16'h0000) begin n_err++; $display("FAIL clear_3ff: got %h want 0000", q_b); end
        n_cmp++; if (q_a !== 16'h0000) begin n_err++; $display("FAIL init_ignored_3fe: got %h want 0000", q_a); end
        idle();
`endif
    endtask

    task automatic test_write_through();
        drive(1'b1, 10'h000, 16'h1234, 1'b0, 10'h000, 16'h0);
        cycle();
        n_cmp++; if (q_a !== 16'h1234) begin n_err++; $display("FAIL wt_q_a: got %h want 1234", q_a); end
        drive(1'b0, 10'h000, 16'h0, 1'b0, 10'h000, 16'h0);
        cycle();
        n_cmp++; if (q_b !== 16'h1234) begin n_err++; $display("FAIL wt_read_b: got %h want 1234", q_b); end
        n_cmp++; if (q_a !== 16'h1234) begin n_err++; $display("FAIL wt_read_a: got %h want 1234", q_a); end
        idle();
    endtask

    task automatic test_collision();
        drive(1'b1, 10'h1fe, 16'hAAAA, 1'b1, 10'h1fe, 16'h5555);
        cycle();
        n_cmp++; if (q_a !== 16'hAAAA) begin n_err++; $display("FAIL coll_q_a: got %h want aaaa", q_a); end
        n_cmp++; if (q_b !== 16'hAAAA) begin n_err++; $display("FAIL coll_q_b: got %h want aaaa", q_b); end
        drive(1'b0, 10'h1fe, 16'h0, 1'b0, 10'h1fe, 16'h0);
        cycle();
        n_cmp++; if (q_a !== 16'hAAAA) begin n_err++; $display("FAIL coll_read_a: got %h want aaaa", q_a); end
        n_cmp++; if (q_b !== 16'hAAAA) begin n_err++; $display("FAIL coll_read_b: got %h want aaaa", q_b); end
        idle();
    endtask

    task automatic test_read_during_write();
        // seed known old words so the check does not rely on the clear
        drive(1'b1, 10'h300, 16'h1111, 1'b1, 10'h200, 16'h0000);
        cycle();
        drive(1'b1, 10'h200, 16'hBEEF, 1'b0, 10'h200, 16'h0);
        cycle();
        n_cmp++; if (q_b !== 16'h0000) begin n_err++; $display("FAIL rdw_b_old: got %h want 0000", q_b); end
        n_cmp++; if (q_a !== 16'hBEEF) begin n_err++; $display("FAIL rdw_a_wt: got %h want beef", q_a); end
        drive(1'b0, 10'h300, 16'h0, 1'b1, 10'h300, 16'hCAFE);
        cycle();
        n_cmp++; if (q_b !== 16'hCAFE) begin n_err++; $display("FAIL rdw_b_wt: got %h want cafe", q_b); end
        n_cmp++; if (q_a !== 16'h1111) begin n_err++; $display("FAIL rdw_a_old: got %h want 1111", q_a); end
        drive(1'b0, 10'h300, 16'h0, 1'b0, 10'h200, 16'h0);
        cycle();
        n_cmp++; if (q_b !== 16'hBEEF) begin n_err++; $display("FAIL rdw_b_new: got %h want beef", q_b); end
        n_cmp++; if (q_a !== 16'hCAFE) begin n_err++; $display("FAIL rdw_a_new: got %h want cafe", q_a); end
        idle();
    endtask

    task automatic test_independent();
        drive(1'b1, 10'h010, 16'h0A0A, 1'b1, 10'h020, 16'h0B0B);
        cycle();
        n_cmp++; if (q_a !== 16'h0A0A) begin n_err++; $display("FAIL ind_q_a: got %h want 0a0a", q_a); end
        n_cmp++; if (q_b !== 16'h0B0B) begin n_err++; $display("FAIL ind_q_b: got %h want 0b0b", q_b); end
        drive(1'b0, 10'h020, 16'h0, 1'b0, 10'h010, 16'h0);
        cycle();
        n_cmp++; if (q_a !== 16'h0B0B) begin n_err++; $display("FAIL ind_cross_a: got %h want 0b0b", q_a); end
        n_cmp++; if (q_b !== 16'h0A0A) begin n_err++; $display("FAIL ind_cross_b: got %h want 0a0a", q_b); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 8; i++) begin
            a = ADDR_W'(10'h100 + i);
            d = DATA_W'(16'h5A00 + i);
            drive(1'b1, a, d, 1'b0, a - 1'b1, 16'h0);
            cycle();
            n_cmp++; if (q_a !== d) begin n_err++; $display("FAIL b2b_wt[%0d]: got %h want %h", i, q_a, d); end
            if (i > 0) begin
                n_cmp++;
                if (q_b !== d - 1'b1) begin n_err++; $display("FAIL b2b_prev[%0d]: got %h want %h", i, q_b, d - 1'b1); end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int edges;
        drive(1'b1, 10'h201, 16'h0201, 1'b0, 10'h000, 16'h0);
        cycle();
        n_cmp++; if (q_a !== 16'h0201) begin n_err++; $display("FAIL mr_write: got %h want 0201", q_a); end
        rst = 1'b0;
        #1;
        n_cmp++; if (q_a !== 16'h0000 || q_b !== 16'h0000) begin n_err++; $display("FAIL mr_q_async: got %h/%h want 0000/0000", q_a, q_b); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mr_ready_async: got %b want 0", ready); end
        drive(1'b1, 10'h201, 16'h7777, 1'b1, 10'h202, 16'h7777);
        repeat (3) cycle();
        n_cmp++; if (q_a !== 16'h0000 || ready !== 1'b0) begin n_err++; $display("FAIL mr_hold: got q_a=%h ready=%b want 0000/0", q_a, ready); end
        idle();
        edges = 0;
        rst   = 1'b1;
        while (ready !== 1'b1 && edges < WAIT_LIMIT) begin
            cycle();
            edges++;
        end
        n_cmp++; if (edges !== INIT_CYCLES) begin n_err++; $display("FAIL mr_reclear: ready after %0d edges want %0d", edges, INIT_CYCLES); end
`ifdef MEMTEST_RAM_INIT_EN
        drive(1'b0, 10'h201, 16'h0, 1'b0, 10'h1fe, 16'h0);
        cycle();
        n_cmp++; if (q_a !== 16'h0000) begin n_err++; $display("FAIL mr_cleared_201: got %h want 0000", q_a); end
        n_cmp++; if (q_b !== 16'h0000) begin n_err++; $display("FAIL mr_cleared_1fe: got %h want 0000", q_b); end
`endif
        idle();
    endtask

    // sequence and report
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_power_up();
        test_write_through();
        test_collision();
        test_read_during_write();
        test_independent();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
